// File: rtl/f1_pkg.sv
// Shared FSM state type and light-pattern constants for the F1 reaction timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_ARMED,
    ST_TIMING,
    ST_DONE
  } state_t;

  localparam logic [7:0] LIGHTS_ALL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF = 8'h00;

endpackage

// File: rtl/f1_reaction_timer_if.sv
// Light/button inputs and result outputs of the reaction timer, bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: none; valid is a one-cycle pulse with no ready.
interface f1_reaction_timer_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       lights;
  logic             btn;
  logic [WIDTH-1:0] react_time;
  logic             valid;
  logic             jump_start;
  logic             busy;

  // Stimulus side: drives lights/button, observes the result.
  modport master (
    output lights, btn,
    input  react_time, valid, jump_start, busy
  );

  // Timer side.
  modport slave (
    input  lights, btn,
    output react_time, valid, jump_start, busy
  );
endinterface

// File: rtl/rt_prescaler.sv
// Divides clk by N+1 into a one-cycle timing-unit tick.
// Latency: tick is combinational from the count; first tick N cycles after clr drops.
// Backpressure: en low freezes the count; clr forces it back to zero.
module rt_prescaler #(
  parameter logic [15:0] N = 16'd999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = en & ~clr & (r_cnt == N);

  // Free-running modulo-(N+1) counter, held while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (clr) begin
      r_cnt <= 16'd0;
    end else if (en) begin
      r_cnt <= (r_cnt == N) ? 16'd0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 start-lights reaction timer; optional jump-start detection via F1_JUMP_DETECT_EN.
// Latency: result and valid appear one cycle after the button edge / saturation.
// Backpressure: none; en low freezes FSM, prescaler, counter and edge register.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int          WIDTH  = 16,
  parameter logic [15:0] N_TICK = 16'd999
) (
  input logic               clk,
  input logic               rst,
  input logic               en,
  f1_reaction_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_next;
  logic             r_btn_q;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_react;
  logic             r_valid;
  logic             w_edge;
  logic             w_tick;
  logic             w_busy;
  logic             w_meas_evt;
  logic             w_sat_evt;
  logic             w_enter_timing;
`ifdef F1_JUMP_DETECT_EN
  logic             w_jump_evt;
  logic             r_jump;
`endif

  // Only rising edges count; a held button never re-triggers.
  assign w_edge = en & bus.btn & ~r_btn_q;

  // Prescaler is held in clear outside TIMING so each run starts at a unit boundary.
  rt_prescaler #(.N(N_TICK)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (r_state != ST_TIMING),
    .o_tick (w_tick)
  );

  // Button history for edge detection, frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst)     r_btn_q <= 1'b0;
    else if (en) r_btn_q <= bus.btn;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)     r_state <= ST_IDLE;
    else if (en) r_state <= w_next;
  end

  // Next-state logic; later assignments in a branch take priority.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.lights != LIGHTS_OFF) w_next = ST_ARMING;
      end
      ST_ARMING: begin
        if (bus.lights == LIGHTS_ALL)      w_next = ST_ARMED;
        else if (bus.lights == LIGHTS_OFF) w_next = ST_IDLE;
`ifdef F1_JUMP_DETECT_EN
        if (w_edge) w_next = ST_DONE;
`endif
      end
      ST_ARMED: begin
        if (bus.lights == LIGHTS_OFF) w_next = ST_TIMING;
`ifdef F1_JUMP_DETECT_EN
        // A press coinciding with lights-out is still a jump start.
        if (w_edge) w_next = ST_DONE;
`endif
      end
      ST_TIMING: begin
        if (w_edge || (r_cnt == CNT_MAX)) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.btn && (bus.lights == LIGHTS_OFF)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state outputs and the events that update the result registers.
  always_comb begin
    w_busy         = 1'b0;
    w_meas_evt     = 1'b0;
    w_sat_evt      = 1'b0;
    w_enter_timing = 1'b0;
`ifdef F1_JUMP_DETECT_EN
    w_jump_evt     = 1'b0;
`endif
    case (r_state)
      ST_ARMING: begin
        w_busy = 1'b1;
`ifdef F1_JUMP_DETECT_EN
        w_jump_evt = w_edge;
`endif
      end
      ST_ARMED: begin
        w_busy         = 1'b1;
        w_enter_timing = en & (w_next == ST_TIMING);
`ifdef F1_JUMP_DETECT_EN
        w_jump_evt = w_edge;
`endif
      end
      ST_TIMING: begin
        w_busy     = 1'b1;
        w_meas_evt = w_edge;
        w_sat_evt  = en & ~w_edge & (r_cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  // Reaction counter and result capture; the edge samples the pre-increment count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_react <= '0;
      r_valid <= 1'b0;
    end else begin
`ifdef F1_JUMP_DETECT_EN
      r_valid <= w_meas_evt | w_sat_evt | w_jump_evt;
`else
      r_valid <= w_meas_evt | w_sat_evt;
`endif
      if (w_enter_timing) begin
        r_cnt <= '0;
      end else if ((r_state == ST_TIMING) && w_tick && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_meas_evt)     r_react <= r_cnt;
      else if (w_sat_evt) r_react <= CNT_MAX;
    end
  end

`ifdef F1_JUMP_DETECT_EN
  // Jump-start flag: set by an early press, cleared when a fresh run starts.
  always_ff @(posedge clk) begin
    if (rst)                 r_jump <= 1'b0;
    else if (w_enter_timing) r_jump <= 1'b0;
    else if (w_jump_evt)     r_jump <= 1'b1;
  end
  assign bus.jump_start = r_jump;
`else
  assign bus.jump_start = 1'b0;
`endif

  assign bus.react_time = r_react;
  assign bus.valid      = r_valid;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Drives two timers (16-bit and 4-bit result) with the same light/button stimulus
// and compares them with a unit-count model: result = enabled TIMING cycles before
// the press divided by (N_TICK+1), saturated to the result width.
module tb_f1_reaction_timer;

  localparam int N_T = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       btn;
  logic [7:0] lights;

  int n_chk    = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_v16    = 0;
  int n_v4     = 0;
  int exp_v16  = 0;
  int exp_v4   = 0;
  int exp_r16  = 0;
  int exp_r4   = 0;
  int exp_jump = 0;

  always #5 clk = ~clk;

  f1_reaction_timer_if #(.WIDTH(16)) if16 ();
  f1_reaction_timer_if #(.WIDTH(4))  if4 ();

  assign if16.lights = lights;
  assign if16.btn    = btn;
  assign if4.lights  = lights;
  assign if4.btn     = btn;

  f1_reaction_timer #(.WIDTH(16), .N_TICK(16'(N_T))) u16 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if16)
  );

  f1_reaction_timer #(.WIDTH(4), .N_TICK(16'(N_T))) u4 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if4)
  );

  // Count every valid pulse, including ones outside the checking windows.
  always @(negedge clk) begin
    if (if16.valid === 1'b1) n_v16++;
    if (if4.valid === 1'b1)  n_v4++;
  end

  // Safety net: the sequence is cycle-exact, this only fires on a broken run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  function automatic int model_units(input int cycles, input int width);
    int units;
    int maxv;
    units = cycles / (N_T + 1);
    maxv  = (1 << width) - 1;
    return (units > maxv) ? maxv : units;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lights_up(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      lights = 8'((16'd1 << i) - 16'd1);
      tick(1);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "/pulses16"}, n_v16, exp_v16);
    check({tag, "/pulses4"},  n_v4,  exp_v4);
  endtask

  // Press now; 'counted' is the number of enabled TIMING cycles already elapsed.
  task automatic measure(input int counted, input string tag);
    btn = 1'b1;
    tick(1);
    exp_r16  = model_units(counted, 16);
    exp_r4   = model_units(counted, 4);
    exp_v16++;
    exp_v4++;
    exp_jump = 0;
    check({tag, "/valid"},  if16.valid,      1);
    check({tag, "/react16"}, if16.react_time, exp_r16);
    check({tag, "/jump16"}, if16.jump_start, exp_jump);
    tick(1);
    check({tag, "/valid_end"}, if16.valid, 0);
    btn = 1'b0;
    tick(1);
    check({tag, "/busy16"}, if16.busy,       0);
    check({tag, "/react4"}, if4.react_time,  exp_r4);
    check({tag, "/jump4"},  if4.jump_start,  exp_jump);
    check_counts(tag);
  endtask

  task automatic race(input int d, input string tag);
    lights_up(1, 8);
    lights = 8'h00;
    tick(1);
    tick(d);
    measure(d, tag);
  endtask

`ifdef F1_JUMP_DETECT_EN
  task automatic check_jump(input string tag);
    exp_v16++;
    exp_v4++;
    exp_jump = 1;
    check({tag, "/valid"},   if16.valid,      1);
    check({tag, "/jump16"},  if16.jump_start, 1);
    check({tag, "/react16"}, if16.react_time, exp_r16);
    check({tag, "/busy16"},  if16.busy,       0);
    check({tag, "/jump4"},   if4.jump_start,  1);
    check({tag, "/react4"},  if4.react_time,  exp_r4);
    btn    = 1'b0;
    lights = 8'h00;
    tick(1);
    check({tag, "/valid_end"}, if16.valid, 0);
    check({tag, "/idle"},      if16.busy,  0);
    check_counts(tag);
  endtask
`endif

  initial begin
    int d;
    int a;
    int b;
    rst    = 1'b1;
    en     = 1'b1;
    btn    = 1'b0;
    lights = 8'h00;
    tick(3);
    check("reset/valid16", if16.valid,      0);
    check("reset/react16", if16.react_time, 0);
    check("reset/jump16",  if16.jump_start, 0);
    check("reset/busy16",  if16.busy,       0);
    check("reset/react4",  if4.react_time,  0);
    check("reset/busy4",   if4.busy,        0);
    rst = 1'b0;
    tick(1);

    // Press 40 cycles into TIMING: ten full units.
    race(40, "lights_out40");
    // Press in the cycle the tick that would make the count 6 fires.
    race(23, "tick_edge");
    // No press within 64 cycles: the 4-bit timer saturates on its own.
    race(64, "saturate");

    for (int k = 0; k < 5; k++) begin
      d = $urandom_range(0, 100);
      race(d, "random");
    end

    // Press while lights show 1F (ARMING).
    lights_up(1, 5);
    check("arming/busy", if16.busy, 1);
    btn = 1'b1;
    tick(1);
`ifdef F1_JUMP_DETECT_EN
    check_jump("jump_arming");
`else
    check("nojump_arming/valid", if16.valid, 0);
    check("nojump_arming/busy",  if16.busy,  1);
    check("nojump_arming/jump",  if16.jump_start, 0);
    btn = 1'b0;
    tick(1);
    lights_up(6, 8);
    lights = 8'h00;
    tick(1);
    tick(12);
    measure(12, "nojump_arming");
`endif

    // Press in the same cycle as lights-out.
    lights_up(1, 8);
    lights = 8'h00;
    btn    = 1'b1;
    tick(1);
`ifdef F1_JUMP_DETECT_EN
    check_jump("jump_lights_out");
    race(17, "after_jump");
`else
    check("held_btn/valid", if16.valid, 0);
    check("held_btn/busy",  if16.busy,  1);
    btn = 1'b0;
    tick(1);
    tick(10);
    measure(11, "held_btn");
`endif

    // Lights drop back to 00 while ARMING: aborted, no result.
    lights_up(1, 3);
    lights = 8'h00;
    tick(1);
    check("abort/busy16", if16.busy, 0);
    check("abort/busy4",  if4.busy,  0);
    tick(1);
    check_counts("abort");

    // en low for 20 cycles mid-measurement: frozen cycles do not count.
    a = $urandom_range(3, 20);
    b = $urandom_range(0, 30);
    lights_up(1, 8);
    lights = 8'h00;
    tick(1);
    tick(a);
    en = 1'b0;
    tick(20);
    check("freeze/busy16", if16.busy, 1);
    check_counts("freeze");
    en = 1'b1;
    tick(b);
    measure(a + b, "freeze");

    // Reset with the count at 7.
    lights_up(1, 8);
    lights = 8'h00;
    tick(1);
    tick(29);
    rst = 1'b1;
    tick(1);
    exp_r16 = 0;
    exp_r4  = 0;
    check("rst_timing/busy16",  if16.busy,       0);
    check("rst_timing/react16", if16.react_time, 0);
    check("rst_timing/valid16", if16.valid,      0);
    check("rst_timing/busy4",   if4.busy,        0);
    check("rst_timing/react4",  if4.react_time,  0);
    rst = 1'b0;
    tick(1);
    check("rst_timing/valid_after", if16.valid, 0);
    check_counts("rst_timing");

    d = $urandom_range(0, 80);
    race(d, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter WIDTH, default 16: width of the reaction-time counter and result.
REQ-002 Parameter N_TICK, default 16'd999: prescaler divides clk by N_TICK+1 to give one timing unit.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  global enable; low freezes FSM, prescaler, counter and edge register.
REQ-006 lights  input  8  light pattern driven by the start-sequence FSM.
REQ-007 btn  input  1  player button, already synchronous to clk, active-high level.
REQ-008 react_time  output  WIDTH  measured reaction time in timing units.
REQ-009 valid  output  1  one-cycle pulse when react_time or jump_start is updated.
REQ-010 jump_start  output  1  button pressed before lights-out.
REQ-011 busy  output  1  high in ARMING, ARMED and TIMING.

Function
REQ-012 Button edge SHALL be btn & ~btn_q, with btn_q registered when en=1; only edges act, and held levels are ignored.
REQ-013 States SHALL be IDLE, ARMING, ARMED, TIMING and DONE.
REQ-014 IDLE -> ARMING when lights != 8'h00.
REQ-015 ARMING -> ARMED when lights == 8'hFF.
REQ-016 ARMED -> TIMING when lights == 8'h00; counter and prescaler cleared on entry; jump_start cleared on entry.
REQ-017 In TIMING, on each prescaler tick the counter SHALL increment, saturating at all-ones.
REQ-018 In TIMING, on a button edge: react_time <= counter value in that cycle, excluding any same-cycle increment; valid pulses; next state DONE.
REQ-019 In TIMING, on counter saturation with no edge: react_time <= all-ones; valid pulses; next state DONE.
REQ-020 valid SHALL rise in the cycle after the qualifying event, giving one cycle of latency.
REQ-021 DONE -> IDLE when btn == 0 and lights == 8'h00.
REQ-022 react_time and jump_start SHALL hold their values until next updated.
REQ-023 If lights return to 8'h00 while in ARMING, the FSM SHALL go to IDLE with no valid pulse (aborted sequence).

Reset
REQ-024 On rst: state IDLE; counter, prescaler, btn_q, react_time = 0; valid, jump_start, busy = 0.
REQ-025 rst SHALL take priority over en and over any in-flight measurement; no valid pulse results from a reset.

Configuration
REQ-026 With F1_JUMP_DETECT_EN defined, a button edge in ARMING or ARMED SHALL set jump_start=1, pulse valid one cycle later, leave react_time unchanged and go to DONE.
REQ-027 In ARMED, if a button edge and lights == 8'h00 occur in the same cycle, the edge SHALL win and the event counts as a jump start.
REQ-028 Without F1_JUMP_DETECT_EN, button edges in ARMING and ARMED SHALL be ignored, and jump_start SHALL be tied to 0.

Structure
REQ-029 Package f1_pkg SHALL hold the state enum typedef and the constants LIGHTS_ALL = 8'hFF and LIGHTS_OFF = 8'h00.
REQ-030 The prescaler SHALL be sub-module rt_prescaler, with ports clk, rst, en and clr, parameter N, and a one-cycle tick output.
REQ-031 FSM, counter and result registers SHALL reside in f1_reaction_timer.

Verification
REQ-032 Scenario, with N_TICK=3 and WIDTH=16: lights 01, 03 ... FF, then 00; btn edge 40 cycles after lights-out -> valid pulse once, react_time = 10, jump_start = 0.
REQ-033 Scenario: btn edge on the cycle that tick fires with counter = 5 -> react_time = 5.
REQ-034 Scenario, macro on: btn edge while lights = 8'h1F -> jump_start = 1, valid pulses, react_time unchanged; macro off: no valid, FSM continues to TIMING.
REQ-035 Scenario: WIDTH=4, no button for 64 cycles after lights-out -> valid pulse, react_time = 4'hF.
REQ-036 Scenario: rst asserted mid-TIMING with counter = 7 -> next cycle: state IDLE, react_time = 0, busy = 0, no valid.
REQ-037 Scenario: en held low 20 cycles during TIMING -> counter is unchanged, and the measured time excludes the frozen cycles.
